// File: rtl/cic_pkg.sv
// cic_pkg: shared constants and helpers for the CIC decimator.
//
// Contents:
//   CIC_PARAMS_LEGAL - macro, true when a parameter set is legal
//                      (DECIM >= 2, 1 <= STAGES <= 6, OUT_WIDTH <= ACC_WIDTH).
//   clog2            - ceiling log2 constant function.
//   acc_width        - internal accumulator width IN_WIDTH + STAGES*clog2(DECIM).
//   shift_width      - number of LSBs dropped at the output, ACC_WIDTH - OUT_WIDTH.
//
// Optional feature macro used by the users of this package: CIC_ROUND_EN.

`ifndef CIC_PKG_SV
`define CIC_PKG_SV

`define CIC_PARAMS_LEGAL(decim, stages, out_w, acc_w) \
    (((decim) >= 2) && ((stages) >= 1) && ((stages) <= 6) && ((out_w) <= (acc_w)))

package cic_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Bit growth of an N-stage, ratio-R, M=1 CIC is N*clog2(R).
    function automatic int unsigned acc_width(input int unsigned in_w,
                                              input int unsigned stages,
                                              input int unsigned decim);
        return in_w + stages * clog2(decim);
    endfunction

    function automatic int unsigned shift_width(input int unsigned in_w,
                                                input int unsigned stages,
                                                input int unsigned decim,
                                                input int unsigned out_w);
        return acc_width(in_w, stages, decim) - out_w;
    endfunction

endpackage

`endif

// File: rtl/cic_channel.sv
// cic_channel: one CIC data path (integrator chain, comb chain, output slice).
//
// Ports:
//   clk      - system clock
//   reset    - synchronous active-high reset, clears every register
//   in_valid - integrators advance only when high
//   capture  - decimation instant; latch the updated last integrator into the comb input
//   tok      - token pipeline from the shared controller; tok[k] marks valid data at the
//              input of comb stage k, tok[STAGES] marks a valid comb result
//   x_in     - signed input sample
//   y_out    - signed decimated output, held between updates
//
// Macro CIC_ROUND_EN selects round-half-up with positive saturation instead of
// truncation; it does not change latency.

module cic_channel
    import cic_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 42,
    parameter int unsigned STAGES    = 3,
    parameter int unsigned DECIM     = 64,
    parameter int unsigned OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 capture,
    input  logic [STAGES:0]      tok,
    input  logic [IN_WIDTH-1:0]  x_in,
    output logic [OUT_WIDTH-1:0] y_out
);

    localparam int unsigned ACC_WIDTH = acc_width(IN_WIDTH, STAGES, DECIM);
    localparam int unsigned SHIFT     = shift_width(IN_WIDTH, STAGES, DECIM, OUT_WIDTH);

    // Plain modular arithmetic: unsigned add/sub gives two's complement wrap, which the
    // CIC relies on.
    logic [ACC_WIDTH-1:0] int_q  [STAGES];
    logic [ACC_WIDTH-1:0] int_d  [STAGES];
    logic [ACC_WIDTH-1:0] cap_q;
    logic [ACC_WIDTH-1:0] cap_d;
    logic [ACC_WIDTH-1:0] comb_q [STAGES];
    logic [ACC_WIDTH-1:0] comb_d [STAGES];
    logic [ACC_WIDTH-1:0] dly_q  [STAGES];
    logic [ACC_WIDTH-1:0] dly_d  [STAGES];
    logic [ACC_WIDTH-1:0] comb_in [STAGES];
    logic [ACC_WIDTH-1:0] comb_last;
    logic [ACC_WIDTH-1:0] x_ext;
    logic [OUT_WIDTH-1:0] y_q;
    logic [OUT_WIDTH-1:0] y_d;
    logic [OUT_WIDTH-1:0] y_res;

    assign x_ext     = {{(ACC_WIDTH - IN_WIDTH){x_in[IN_WIDTH-1]}}, x_in};
    assign comb_last = comb_q[STAGES-1];
    assign y_out     = y_q;

    // Comb stage k reads the capture register (k = 0) or the previous comb stage.
    always_comb begin
        comb_in[0] = cap_q;
        for (int k = 1; k < STAGES; k++) begin
            comb_in[k] = comb_q[k-1];
        end
    end

    // Output slice.
    if (SHIFT == 0) begin : g_no_shift
        assign y_res = comb_last;
    end else begin : g_shift
`ifdef CIC_ROUND_EN
        localparam logic [ACC_WIDTH:0] RND_HALF = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);

        // One guard bit catches the only overflow possible when adding a positive half.
        logic [ACC_WIDTH:0] rnd_sum;
        logic               unused_rnd_lsbs;

        assign rnd_sum         = {comb_last[ACC_WIDTH-1], comb_last} + RND_HALF;
        assign unused_rnd_lsbs = ^rnd_sum[SHIFT-1:0];

        always_comb begin
            y_res = rnd_sum[ACC_WIDTH-1:SHIFT];
            if (rnd_sum[ACC_WIDTH:ACC_WIDTH-1] == 2'b01) begin
                y_res                = '1;
                y_res[OUT_WIDTH-1]   = 1'b0;
            end
        end
`else
        logic unused_trunc_lsbs;

        // Dropping LSBs of a two's complement value truncates toward -inf.
        assign y_res             = comb_last[ACC_WIDTH-1:SHIFT];
        assign unused_trunc_lsbs = ^comb_last[SHIFT-1:0];
`endif
    end

    always_comb begin
        int_d  = int_q;
        cap_d  = cap_q;
        comb_d = comb_q;
        dly_d  = dly_q;
        y_d    = y_q;

        // Every integrator reads the pre-update value of its predecessor.
        if (in_valid) begin
            int_d[0] = int_q[0] + x_ext;
            for (int k = 1; k < STAGES; k++) begin
                int_d[k] = int_q[k] + int_q[k-1];
            end
        end

        // capture implies in_valid, so int_d holds the value written on this edge.
        if (capture) begin
            cap_d = int_d[STAGES-1];
        end

        // Delay registers only move with a token, giving M = 1 at the decimated rate.
        for (int k = 0; k < STAGES; k++) begin
            if (tok[k]) begin
                comb_d[k] = comb_in[k] - dly_q[k];
                dly_d[k]  = comb_in[k];
            end
        end

        if (tok[STAGES]) begin
            y_d = y_res;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            int_q  <= '{default: '0};
            cap_q  <= '0;
            comb_q <= '{default: '0};
            dly_q  <= '{default: '0};
            y_q    <= '0;
        end else begin
            int_q  <= int_d;
            cap_q  <= cap_d;
            comb_q <= comb_d;
            dly_q  <= dly_d;
            y_q    <= y_d;
        end
    end

endmodule

// File: rtl/cic_decimator_iq.sv
// cic_decimator_iq: dual-channel (I/Q) CIC decimator for lock-in mixer products.
//
// Ports:
//   clk            - system clock
//   reset          - synchronous active-high reset
//   in_valid       - sample strobe, one sample accepted per high cycle
//   phase_in       - signed I sample, IN_WIDTH bits
//   quadrature_in  - signed Q sample, IN_WIDTH bits
//   phase_out      - signed decimated I, OUT_WIDTH bits, held between pulses
//   quadrature_out - signed decimated Q, OUT_WIDTH bits, held between pulses
//   out_valid      - one-cycle pulse per decimated I/Q pair
//
// The edge accepting every DECIM-th sample (edge T) launches a token; out_valid is high
// in the cycle after edge T+STAGES+1. I and Q share the counter and token pipeline.
//
// Optional macro CIC_ROUND_EN: round-half-up with positive saturation at the output
// instead of truncation.

module cic_decimator_iq
    import cic_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 42,
    parameter int unsigned STAGES    = 3,
    parameter int unsigned DECIM     = 64,
    parameter int unsigned OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  phase_in,
    input  logic [IN_WIDTH-1:0]  quadrature_in,
    output logic [OUT_WIDTH-1:0] phase_out,
    output logic [OUT_WIDTH-1:0] quadrature_out,
    output logic                 out_valid
);

    localparam int unsigned ACC_WIDTH = acc_width(IN_WIDTH, STAGES, DECIM);
    localparam int unsigned CNT_WIDTH = (clog2(DECIM) > 0) ? clog2(DECIM) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DECIM - 1);

    if (!(`CIC_PARAMS_LEGAL(DECIM, STAGES, OUT_WIDTH, ACC_WIDTH))) begin : g_param_check
        $error("cic_decimator_iq: illegal DECIM/STAGES/OUT_WIDTH combination");
    end

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [STAGES:0]      tok_q;
    logic [STAGES:0]      tok_d;
    logic                 out_valid_q;
    logic                 out_valid_d;
    logic                 decim_hit;

    assign decim_hit = in_valid && (cnt_q == CNT_LAST);
    assign out_valid = out_valid_q;

    always_comb begin
        cnt_d = cnt_q;
        if (in_valid) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_WIDTH'(1);
        end
        // tok[0]: capture register valid; tok[k]: comb stage k-1 valid;
        // tok[STAGES]: comb result valid, output register loads on this bit.
        tok_d       = {tok_q[STAGES-1:0], decim_hit};
        out_valid_d = tok_q[STAGES];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            tok_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            tok_q       <= tok_d;
            out_valid_q <= out_valid_d;
        end
    end

    cic_channel #(
        .IN_WIDTH  (IN_WIDTH),
        .STAGES    (STAGES),
        .DECIM     (DECIM),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_chan_i (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .capture  (decim_hit),
        .tok      (tok_q),
        .x_in     (phase_in),
        .y_out    (phase_out)
    );

    cic_channel #(
        .IN_WIDTH  (IN_WIDTH),
        .STAGES    (STAGES),
        .DECIM     (DECIM),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_chan_q (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .capture  (decim_hit),
        .tok      (tok_q),
        .x_in     (quadrature_in),
        .y_out    (quadrature_out)
    );

endmodule
